// File: rtl/ble_ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state codes and region defaults for the BLE PHY slave front end.
package ble_ahb_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR1     = 3'd5;
  localparam logic [2:0] ST_ERR2     = 3'd6;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int REG_SPAN_DEF = 'h10;

endpackage

// File: rtl/ahb_slave_if_ble.sv
// AHB-Lite slave front end: one strobe per transfer to the PHY decoder; zero-wait writes,
// reads stall 1 (register) or 1+MEM_RD_LAT (memory) cycles; non-word sizes get a two-cycle ERROR.
module ahb_slave_if_ble
  import ble_ahb_pkg::*;
#(
  parameter int AD         = 12,
  parameter int DW         = 32,
  parameter int MEM_RD_LAT = 1,
  parameter int REG_SPAN   = REG_SPAN_DEF
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AD-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [DW-1:0] HWDATA,
  output logic [DW-1:0] HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [AD-1:0] address,
  output logic          wenable,
  output logic          renable,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata_reg,
  input  logic [DW-1:0] rdata_mem
);

  localparam int              CW       = $clog2(MEM_RD_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MEM_RD_LAT - 1);
  localparam logic [AD-1:0]   SPAN     = AD'(REG_SPAN);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] hrdata_q;
  logic          ready_state, accept, is_reg;

  // Only states that present HREADYOUT=1 may overlap the next address phase.
  assign ready_state = (state == ST_IDLE) || (state == ST_WR) ||
                       (state == ST_RD_DONE) || (state == ST_ERR2);
  assign accept = HSEL && HREADY && ready_state &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign is_reg = (address < SPAN);

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_WR, ST_RD_DONE, ST_ERR2: begin
        if (accept) begin
          if (HSIZE != HSIZE_WORD) state_nxt = ST_ERR1;
          else if (HWRITE)         state_nxt = ST_WR;
          else                     state_nxt = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_nxt = is_reg ? ST_RD_DONE : ST_RD_WAIT;
      ST_RD_WAIT:  state_nxt = (cnt == '0) ? ST_RD_DONE : ST_RD_WAIT;
      ST_ERR1:     state_nxt = ST_ERR2;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      address  <= '0;
      cnt      <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) address <= HADDR;
      case (state)
        ST_RD_ISSUE: begin
          if (is_reg) hrdata_q <= rdata_reg;
          else        cnt      <= CNT_LOAD;
        end
        ST_RD_WAIT: begin
          if (cnt == '0) hrdata_q <= rdata_mem;
          else           cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wenable   = (state == ST_WR);
  assign renable   = (state == ST_RD_ISSUE);
  assign wdata     = wenable ? HWDATA : '0;
  assign HREADYOUT = !((state == ST_RD_ISSUE) || (state == ST_RD_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = hrdata_q;

endmodule
